// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory bank: FSM state encoding and
// the address-width to depth conversion used by the top and the RAM.
package dmem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } dmem_state_e;

    function automatic int dmem_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : dmem_pkg

// File: rtl/dmem_bytelane_ram.sv
// DEPTH x DATA_W single-port RAM split into independent 8-bit lanes, each with
// its own write enable and a registered, enable-gated read port.
module dmem_bytelane_ram
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 6,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = dmem_depth(ADDR_W);

    // One array per lane keeps each lane a plain RAM with a single writer.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                mem[addr] <= wdata[8*gi +: 8];
            end
            if (re) begin
                rd_q <= mem[addr];
            end
        end

        assign rdata[8*gi +: 8] = rd_q;
    end

endmodule : dmem_bytelane_ram

// File: rtl/data_memory_bank.sv
// Parametrised single-port data memory with request handshake, one-cycle
// registered read response and a full-depth hardware clear sequencer.
module data_memory_bank
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 6,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam int                DEPTH    = dmem_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic              ram_we;
    logic              ram_re;
    logic [BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign busy      = (state_q == ST_INIT);
    assign req_ready = (state_q == ST_IDLE) && !clr;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_zero_d  = rsp_zero_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_be      = req_be;
        ram_addr    = req_addr;
        ram_wdata   = req_wdata;

        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_be    = '1;
                ram_addr  = clr_cnt_q;
                ram_wdata = '0;
                if (clr_cnt_q == LAST_IDX) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_INIT;
                end else if (req_valid) begin
                    if (req_wr) begin
                        ram_we = 1'b1;
                    end else begin
                        ram_re      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_zero_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Reset must never disturb memory contents.
        if (!rst) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_zero_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    // The RAM read register cannot be reset, so a reset-time zero is
    // substituted until the first read after reset lands.
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_zero_q ? '0 : ram_rdata;

    dmem_bytelane_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

endmodule : data_memory_bank

// File: tb/tb_data_memory_bank.sv
// Self-checking bench for data_memory_bank: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_data_memory_bank;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;

    data_memory_bank dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ref_mem [DEPTH];
    int          clear_left;
    logic [15:0] exp_data;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own
    // notion of whether a clear is still running.
    task automatic cycle(input logic v, input logic wr, input logic [5:0] a,
                         input logic [15:0] wd, input logic [1:0] be, input logic c);
        logic exp_busy;
        logic exp_rv;
        req_valid = v;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        clr       = c;
        #1;
        exp_busy = (clear_left > 0);
        check("busy", busy, exp_busy);
        check("req_ready", req_ready, !exp_busy && !c);
        exp_rv = 1'b0;
        if (exp_busy) begin
            ref_mem[DEPTH - clear_left] = 16'h0000;
            clear_left--;
        end else if (c) begin
            clear_left = DEPTH;
        end else if (v) begin
            if (wr) begin
                for (int i = 0; i < 2; i++)
                    if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
            end else begin
                exp_rv   = 1'b1;
                exp_data = ref_mem[a];
            end
        end
        @(posedge clk);
        #1;
        check("rsp_valid", rsp_valid, exp_rv);
        check("rsp_data", rsp_data, exp_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 6'd0, 16'h0, 2'b00, 1'b0);
    endtask

    task automatic do_reset(input int n, input logic pend_rd);
        rst       = 1'b0;
        clr       = 1'b0;
        req_valid = pend_rd;
        req_wr    = 1'b0;
        req_addr  = 6'd1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_rsp_valid", rsp_valid, 1'b0);
            check("rst_rsp_data", rsp_data, 16'h0000);
        end
        rst        = 1'b1;
        clear_left = DEPTH;
        exp_data   = 16'h0000;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        clear_left = DEPTH;
        exp_data   = 16'h0000;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        rst = 1'b0; clr = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;

        // Power-up reset and full clear, then every word reads zero.
        do_reset(3, 1'b0);
        idle(DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b1, 1'b0, 6'(k), 16'h0, 2'b00, 1'b0);
            check("clear_zero", rsp_data, 16'h0000);
        end

        // Byte-lane merge and the all-zero enable no-op.
        cycle(1'b1, 1'b1, 6'd5, 16'h1234, 2'b11, 1'b0);
        cycle(1'b1, 1'b1, 6'd5, 16'hABCD, 2'b01, 1'b0);
        cycle(1'b1, 1'b0, 6'd5, 16'h0, 2'b00, 1'b0);
        check("be_merge", rsp_data, 16'h12CD);
        cycle(1'b1, 1'b1, 6'd5, 16'hFFFF, 2'b00, 1'b0);
        cycle(1'b1, 1'b0, 6'd5, 16'h0, 2'b00, 1'b0);
        check("be_none", rsp_data, 16'h12CD);

        // Populate then stream 64 back-to-back reads.
        for (int k = 0; k < DEPTH; k++)
            cycle(1'b1, 1'b1, 6'(k), 16'(k * 16'h0101), 2'b11, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b1, 1'b0, 6'(k), 16'h0, 2'b00, 1'b0);
            check("stream_valid", rsp_valid, 1'b1);
            check("stream_data", rsp_data, 16'(k * 16'h0101));
        end

        // Write immediately followed by a read of the same word.
        cycle(1'b1, 1'b1, 6'd63, 16'hBEEF, 2'b11, 1'b0);
        cycle(1'b1, 1'b0, 6'd63, 16'h0, 2'b00, 1'b0);
        check("wr_then_rd", rsp_data, 16'hBEEF);

        // On-demand clear with a competing read; requests and clr ignored during it.
        cycle(1'b1, 1'b0, 6'd1, 16'h0, 2'b00, 1'b1);
        check("clr_no_rsp", rsp_valid, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 6'($urandom), 16'($urandom), 2'b11,
                  1'($urandom_range(0, 1)));
        cycle(1'b1, 1'b0, 6'd1, 16'h0, 2'b00, 1'b0);
        check("clr_addr1", rsp_data, 16'h0000);

        // Reset 30 cycles into a clear restarts the full sequence.
        for (int k = 0; k < DEPTH; k++)
            cycle(1'b1, 1'b1, 6'(k), 16'($urandom), 2'b11, 1'b0);
        cycle(1'b0, 1'b0, 6'd0, 16'h0, 2'b00, 1'b1);
        idle(30);
        do_reset(1, 1'b0);
        idle(DEPTH);

        // Reset while a read is being accepted drops the response.
        cycle(1'b1, 1'b1, 6'd1, 16'h5A5A, 2'b11, 1'b0);
        cycle(1'b1, 1'b0, 6'd1, 16'h0, 2'b00, 1'b0);
        do_reset(1, 1'b1);
        idle(DEPTH);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 6'($urandom),
                  16'($urandom), 2'($urandom), 1'($urandom_range(0, 99) < 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_data_memory_bank

// File: doc/data_memory_bank.md
# data_memory_bank

Parametrised single-port data memory for the RISC core's load/store path. It is the successor to the fixed 64×16 data memory and adds:
- width, depth and byte-lane generics;
- a valid/ready request handshake and a registered read response with a valid strobe;
- a hardware clear sequencer that zeroes every location after reset or on demand (not just a subset).

It sits between the core's memory stage and any future bus adapter.

## Interface
Parameters:
- DATA_W, 16, data word width; must be a multiple of 8
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
- BE_W, DATA_W/8, byte-enable lanes (derived, not overridable)

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-low reset; low at a rising edge resets.
- clr  in  1  request a full re-clear; sampled only in IDLE.
- req_valid  in  1  request present.
- req_ready  out  1  request may be accepted this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte enables; lane i covers bits [8i+7:8i]; writes only.
- rsp_valid  out  1  one-cycle pulse: rsp_data holds read result.
- rsp_data  out  DATA_W  read data; holds last value between reads.
- busy  out  1  clear sequence in progress.

## Operation
- FSM states: INIT, IDLE.
- Reset (rst low at edge): state ← INIT, clr_cnt ← 0, rsp_valid ← 0, rsp_data ← 0. Memory contents are not touched by reset itself.
- INIT: each edge writes mem[clr_cnt] ← 0 and clr_cnt ← clr_cnt+1. On the edge where clr_cnt == DEPTH-1, the last location is written, clr_cnt ← 0 and state ← IDLE.
- IDLE, clr=1: state ← INIT; no request is accepted that cycle.
- busy = (state == INIT). req_ready = (state == IDLE) && !clr; combinational, independent of req_valid.
- Accept = req_valid && req_ready.
  - Accepted write: for each lane with req_be[i]=1, mem[req_addr] lane i ← req_wdata lane i; other lanes keep their value. No response pulse.
  - Accepted write with req_be all-zero: legal no-op.
  - Accepted read: next edge rsp_data ← mem[req_addr], rsp_valid ← 1.
- rsp_valid is 0 in every cycle not directly following an accepted read.
- clr in INIT is ignored; the sequence is not restarted.
- rst low mid-INIT restarts the clear from address 0. rst low in IDLE with a pending read drops the response (rsp_valid 0, rsp_data 0).
- No back-pressure on responses; the consumer must take rsp_data when rsp_valid is 1.

## Timing
- Clear duration: exactly DEPTH cycles. With rst released before edge 0, req_ready is 1 from the cycle after edge DEPTH-1, with clr=0.
- Read latency: 1 cycle. Request accepted at edge N; rsp_valid=1 and data valid from edge N+1 until edge N+2.
- Throughput: one request per cycle in IDLE; back-to-back reads give back-to-back rsp_valid.
- Write then read of the same address on consecutive cycles returns the new data (write at edge N, read sampled at edge N+1).
- Mixed read/write in consecutive cycles is allowed; a write does not disturb an in-flight rsp_valid.

## Structure
- Shared package dmem_pkg: state enum (INIT, IDLE) and a DEPTH helper function/localparam from ADDR_W.
- One natural sub-module: dmem_bytelane_ram, a plain DEPTH×DATA_W array with per-lane write enable and a registered read port. The clear sequencer drives its write port with be = all-ones and data = 0.
- Top level holds the FSM, clr_cnt, write-port mux (clear vs. request) and the response valid register.

## Test plan
- Reset/clear: hold rst low 3 cycles, release → busy=1 for exactly 64 cycles, req_ready=0 throughout, then read all 64 addresses → every rsp_data = 16'h0000.
- Byte enables: write 0x1234 to addr 5 with be=2'b11, then 0xABCD with be=2'b01 → read addr 5 gives 0x12CD; be=2'b00 write → unchanged 0x12CD.
- Latency/throughput: write addr k = k·0x0101 for k = 0..63, then 64 back-to-back reads → rsp_valid high for 64 consecutive cycles, each one cycle after its request, data matching.
- Write-then-read: write 0xBEEF to addr 63 at edge N, read addr 63 at edge N+1 → rsp_data = 0xBEEF at edge N+2.
- On-demand clear: after the populate above, assert clr with req_valid=1 (read addr 1) → request not accepted, rsp_valid stays 0, busy=1 for 64 cycles, then addr 1 reads 0x0000.
- Reset mid-clear: pull rst low at clear cycle 30 for 1 cycle → busy lasts a further full 64 cycles; rsp_valid and rsp_data are 0 immediately after reset.
